pe_arr_acc: RTL and testbench

Parametrised successor to the single-window PE array. It multiplies PE_ARR_SIZE ifm/wgt pairs per beat, reduces them through a fully registered adder tree, and accumulates that partial sum over a run-time number of input-channel beats. Bias is added once, with optional ReLU and saturation to OUTPUT_WIDTH. It sits between the line-buffer/weight-fetch front end and the output-feature-map writer, with valid/ready handshakes on both sides.

---
 rtl/pe_arr_acc.sv | 185 ++++++++++++++++++
 tb/tb_pe_arr_acc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_arr_acc.sv
// PE array with registered multiply, pipelined adder tree and per-window channel accumulation.
// Bias is added once per window, followed by optional ReLU and saturation to OUTPUT_WIDTH.
module pe_arr_acc #(
  parameter int INPUT_IFM_WIDTH  = 8,
  parameter int INPUT_WGT_WIDTH  = 8,
  parameter int INPUT_BIAS_WIDTH = 8,
  parameter int PAR_WIDTH        = 16,
  parameter int ACC_WIDTH        = 28,
  parameter int OUTPUT_WIDTH     = 20,
  parameter int PE_ARR_SIZE      = 9,
  parameter int MAX_CH           = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [$clog2(MAX_CH+1)-1:0]              cfg_num_ch,
  input  logic                                     cfg_relu,
  input  logic [INPUT_BIAS_WIDTH-1:0]              bias_input,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [PE_ARR_SIZE*INPUT_IFM_WIDTH-1:0]   ifm_input,
  input  logic [PE_ARR_SIZE*INPUT_WGT_WIDTH-1:0]   wgt_input,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUTPUT_WIDTH-1:0]                  ofm_output
);

  localparam int CNT_W    = $clog2(MAX_CH + 1);
  localparam int TREE_LAT = $clog2(PE_ARR_SIZE);
  localparam int PROD_W   = INPUT_IFM_WIDTH + INPUT_WGT_WIDTH;
  localparam int SUM_W    = PAR_WIDTH + TREE_LAT;
  localparam int HALF     = (PE_ARR_SIZE + 1) / 2;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

  // Number of live nodes at a given tree level (level 0 = products).
  function automatic int level_count(input int lvl);
    int n;
    n = PE_ARR_SIZE;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             beat_cnt_q, sum_cnt_q, num_ch_q, cfg_n_eff;
  logic                         relu_q;
  logic signed [INPUT_BIAS_WIDTH-1:0] bias_q;
  logic                         accept, drain_done;

  logic signed [INPUT_IFM_WIDTH-1:0] ifm_q [PE_ARR_SIZE];
  logic signed [INPUT_WGT_WIDTH-1:0] wgt_q [PE_ARR_SIZE];
  logic                              beat_vld_q;
  logic signed [PAR_WIDTH-1:0]       prod_w [PE_ARR_SIZE];
  logic                              prod_vld_q;
  logic [TREE_LAT:1]                 tree_vld_q;
  // Spare slot at index PE_ARR_SIZE keeps the 2j+1 pair index in range for odd sizes.
  logic signed [SUM_W-1:0]           node_q [TREE_LAT+1][PE_ARR_SIZE+1];

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_clip;
  logic [OUTPUT_WIDTH-1:0]      ofm_q, ofm_d;

  assign in_ready   = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept     = in_valid && in_ready;
  assign cfg_n_eff  = (cfg_num_ch == '0) ? CNT_W'(1) : cfg_num_ch;
  assign drain_done = (sum_cnt_q == num_ch_q);
  assign out_valid  = (state_q == OUT);
  assign ofm_output = ofm_q;

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (cfg_n_eff == CNT_W'(1)) ? DRAIN : ACCUM;
      ACCUM:   if (accept && (beat_cnt_q + CNT_W'(1) == num_ch_q)) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      num_ch_q   <= '0;
      relu_q     <= 1'b0;
      bias_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (state_q == IDLE) begin
          beat_cnt_q <= CNT_W'(1);
          num_ch_q   <= cfg_n_eff;
          relu_q     <= cfg_relu;
          bias_q     <= bias_input;
        end else begin
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_vld_q <= 1'b0;
      for (int i = 0; i < PE_ARR_SIZE; i++) begin
        ifm_q[i] <= '0;
        wgt_q[i] <= '0;
      end
    end else begin
      beat_vld_q <= accept;
      if (accept) begin
        for (int i = 0; i < PE_ARR_SIZE; i++) begin
          ifm_q[i] <= ifm_input[i*INPUT_IFM_WIDTH +: INPUT_IFM_WIDTH];
          wgt_q[i] <= wgt_input[i*INPUT_WGT_WIDTH +: INPUT_WGT_WIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PE_ARR_SIZE; i++) begin
      prod_w[i] = PAR_WIDTH'(PROD_W'(ifm_q[i]) * PROD_W'(wgt_q[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_vld_q <= 1'b0;
      tree_vld_q <= '0;
      // NOTE: the node array is cleared on reset so an aborted window leaves no partial sums behind.
      for (int l = 0; l <= TREE_LAT; l++) begin
        for (int j = 0; j <= PE_ARR_SIZE; j++) node_q[l][j] <= '0;
      end
    end else begin
      prod_vld_q    <= beat_vld_q;
      tree_vld_q[1] <= prod_vld_q;
      for (int l = 2; l <= TREE_LAT; l++) tree_vld_q[l] <= tree_vld_q[l-1];
      for (int j = 0; j < PE_ARR_SIZE; j++) node_q[0][j] <= SUM_W'(prod_w[j]);
      node_q[0][PE_ARR_SIZE] <= '0;
      for (int l = 1; l <= TREE_LAT; l++) begin
        for (int j = 0; j < HALF; j++) begin
          if (2*j + 1 < level_count(l-1))
            node_q[l][j] <= node_q[l-1][2*j] + node_q[l-1][2*j+1];
          else if (2*j < level_count(l-1))
            node_q[l][j] <= node_q[l-1][2*j];
          else
            node_q[l][j] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      sum_cnt_q <= '0;
    end else if (tree_vld_q[TREE_LAT]) begin
      if (sum_cnt_q == '0)
        acc_q <= ACC_WIDTH'(bias_q) + ACC_WIDTH'(node_q[TREE_LAT][0]);
      else
        acc_q <= acc_q + ACC_WIDTH'(node_q[TREE_LAT][0]);
      sum_cnt_q <= sum_cnt_q + CNT_W'(1);
    end else if (state_q == OUT && out_ready) begin
      sum_cnt_q <= '0;
    end
  end

  always_comb begin
    acc_clip = (relu_q && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
    if (acc_clip > OUT_MAX)      ofm_d = OUT_MAX[OUTPUT_WIDTH-1:0];
    else if (acc_clip < OUT_MIN) ofm_d = OUT_MIN[OUTPUT_WIDTH-1:0];
    else                         ofm_d = acc_clip[OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)                            ofm_q <= '0;
    else if (state_q == DRAIN && drain_done) ofm_q <= ofm_d;
  end

endmodule

// File: tb/tb_pe_arr_acc.sv
// Self-checking bench for pe_arr_acc: directed vector table, corner sequences,
// and randomized windows scored against a plain-arithmetic window model.
module tb_pe_arr_acc;

  localparam int PE    = 9;
  localparam int IW    = 8;
  localparam int WW    = 8;
  localparam int BW    = 8;
  localparam int OW    = 20;
  localparam int MAXCH = 64;
  localparam int CW    = $clog2(MAXCH + 1);
  localparam int LAT   = 7;
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -OMAX - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     cfg_num_ch;
  logic              cfg_relu;
  logic [BW-1:0]     bias_input;
  logic              in_valid;
  logic              in_ready;
  logic [PE*IW-1:0]  ifm_input;
  logic [PE*WW-1:0]  wgt_input;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     ofm_output;

  int checks = 0;
  int errors = 0;
  int gap_q[$];

  typedef struct {
    int     n;
    bit     relu;
    int     bias;
    int     mode;   // 0: constant ifm/wgt, 1: ifm[i]=i, 2: random
    int     fc;
    int     wc;
    longint exp_val;
  } vec_t;

  vec_t tbl[$];

  pe_arr_acc dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_num_ch (cfg_num_ch),
    .cfg_relu   (cfg_relu),
    .bias_input (bias_input),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ifm_input  (ifm_input),
    .wgt_input  (wgt_input),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ofm_output (ofm_output)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic make_beat(input int mode, input int fc, input int wc,
                           output logic [PE*IW-1:0] f, output logic [PE*WW-1:0] w);
    for (int i = 0; i < PE; i++) begin
      case (mode)
        0: begin f[i*IW +: IW] = IW'(fc); w[i*WW +: WW] = WW'(wc); end
        1: begin f[i*IW +: IW] = IW'(i);  w[i*WW +: WW] = WW'(wc); end
        default: begin f[i*IW +: IW] = IW'($urandom); w[i*WW +: WW] = WW'($urandom); end
      endcase
    end
  endtask

  function automatic longint dot(input logic [PE*IW-1:0] f, input logic [PE*WW-1:0] w);
    longint s;
    s = 0;
    for (int i = 0; i < PE; i++)
      s += longint'($signed(f[i*IW +: IW])) * longint'($signed(w[i*WW +: WW]));
    return s;
  endfunction

  function automatic longint ref_out(input longint raw, input bit relu);
    longint v;
    v = (relu && raw < 0) ? 0 : raw;
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  task automatic junk_inputs();
    logic [PE*IW-1:0] f;
    logic [PE*WW-1:0] w;
    make_beat(2, 0, 0, f, w);
    ifm_input = f;
    wgt_input = w;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic drive_beat(input string name, input logic [PE*IW-1:0] f,
                            input logic [PE*WW-1:0] w);
    int k;
    in_valid  = 1'b1;
    ifm_input = f;
    wgt_input = w;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " beat accepted"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    junk_inputs();
  endtask

  task automatic run_window(input string name, input int n_cfg, input bit relu,
                            input int bias, input int mode, input int fc, input int wc,
                            input int gap_max, input int hold, input bit use_exp,
                            input longint exp_val);
    logic [PE*IW-1:0] f;
    logic [PE*WW-1:0] w;
    logic [OW-1:0]    held;
    longint raw;
    int n_eff, gap, k, bad;
    n_eff = (n_cfg == 0) ? 1 : n_cfg;
    raw = bias;
    for (int b = 0; b < n_eff; b++) begin
      gap = (gap_q.size() > 0) ? gap_q.pop_front() : int'($urandom_range(gap_max, 0));
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      if (b == 0) begin
        cfg_num_ch = CW'(n_cfg);
        cfg_relu   = relu;
        bias_input = BW'(bias);
      end
      make_beat(mode, fc, wc, f, w);
      raw += dot(f, w);
      drive_beat(name, f, w);
      cfg_num_ch = CW'($urandom);
      cfg_relu   = 1'($urandom);
      bias_input = BW'($urandom);
    end
    check({name, " in_ready low after last beat"}, in_ready, 0);
    in_valid = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " latency"}, k, LAT);
    check({name, " ofm"}, $signed(ofm_output), use_exp ? exp_val : ref_out(raw, relu));
    held = ofm_output;
    bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || ofm_output !== held || in_ready) bad++;
    end
    if (hold > 0) check({name, " hold stable"}, bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid cleared"}, out_valid, 0);
    check({name, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    logic [PE*IW-1:0] f;
    logic [PE*WW-1:0] w;
    int k, bad;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_num_ch = '0; cfg_relu = 1'b0; bias_input = '0;
    ifm_input = '0; wgt_input = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset ofm", ofm_output, 0);
    rst = 1'b0;
    #1;
    check("idle in_ready", in_ready, 1);

    tbl.push_back('{1,  0,  3,    0,  1,    2,    21});
    tbl.push_back('{4,  0,  0,    0,  127,  127,  524287});
    tbl.push_back('{4,  0,  0,    0,  -128, 127,  -524288});
    tbl.push_back('{2,  0,  -2,   0,  -1,   5,    -92});
    tbl.push_back('{2,  1,  -2,   0,  -1,   5,    0});
    tbl.push_back('{3,  0,  0,    1,  0,    1,    108});
    tbl.push_back('{0,  0,  -5,   0,  2,    3,    49});
    tbl.push_back('{64, 0,  127,  0,  127,  127,  524287});
    tbl.push_back('{1,  0,  -128, 0,  -128, -128, 147328});
    tbl.push_back('{4,  1,  0,    0,  -128, 127,  0});
    tbl.push_back('{1,  1,  0,    0,  1,    1,    9});
    foreach (tbl[i])
      run_window($sformatf("vec%0d", i), tbl[i].n, tbl[i].relu, tbl[i].bias,
                 tbl[i].mode, tbl[i].fc, tbl[i].wc, 0, 0, 1'b1, tbl[i].exp_val);

    // Input gaps between beats must not change result or latency.
    gap_q = '{0, 2, 5};
    run_window("gaps", 3, 1'b0, 0, 1, 0, 1, 0, 0, 1'b1, 108);

    // Backpressure: result held for 10 cycles with junk beats offered.
    run_window("backpressure", 2, 1'b0, 7, 2, 0, 0, 1, 10, 1'b0, 0);

    // Reset after 2 of 4 beats discards the window.
    cfg_num_ch = CW'(4); cfg_relu = 1'b0; bias_input = '0;
    for (int b = 0; b < 2; b++) begin
      make_beat(0, 50, 50, f, w);
      drive_beat("abort", f, w);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out_valid", out_valid, 0);
    check("abort ofm", ofm_output, 0);
    check("abort in_ready during rst", in_ready, 0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || ofm_output !== '0) bad++;
    end
    check("abort no leftover output", bad, 0);
    run_window("after_abort", 1, 1'b0, 0, 0, 1, 1, 0, 0, 1'b1, 9);

    // Reset coinciding with out_ready drops the result.
    cfg_num_ch = CW'(1); cfg_relu = 1'b0; bias_input = BW'(1);
    make_beat(0, 3, 3, f, w);
    drive_beat("rst_vs_ready", f, w);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_vs_ready ofm before rst", $signed(ofm_output), 82);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_vs_ready out_valid", out_valid, 0);
    check("rst_vs_ready ofm", ofm_output, 0);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_vs_ready in_ready", in_ready, 1);

    // Randomized windows against the model.
    for (int t = 0; t < 40; t++) begin
      run_window($sformatf("rand%0d", t), int'($urandom_range(8, 0)), 1'($urandom),
                 int'($urandom_range(255, 0)) - 128, 2, 0, 0, 2,
                 int'($urandom_range(3, 0)), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
